// File: rtl/mvu_replay_pkg.sv
// rtl/mvu_replay_pkg.sv - shared types and sizing helpers for the MVU input replay buffer
// Contents:
//   clog2_min1     : counter/address width for a range of n values, never below 1 bit
//   beat_width     : bits per stream beat (SIMD activations of ACTIVATION_WIDTH bits)
//   replay_state_e : read-side FSM state (IDLE, REPLAY)
package mvu_replay_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int beat_width(input int simd, input int act_width);
    return simd * act_width;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } replay_state_e;

endpackage

// File: rtl/mvu_replay_mem.sv
// rtl/mvu_replay_mem.sv - simple dual-port vector store, one write port, one registered read port
// Ports:
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr
//   wr_addr : write address (slot*SF + beat)
//   wr_data : beat to store
//   rd_en   : read strobe; rd_data updates one cycle later, otherwise holds
//   rd_addr : read address (slot*SF + beat)
//   rd_data : registered read data
// Contents are not reset so the array maps onto block or distributed RAM.
module mvu_replay_mem
  import mvu_replay_pkg::*;
#(
  parameter int WIDTH   = 192,
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = clog2_min1(ENTRIES)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    // Holding rd_data while rd_en is low lets it act as the first pipeline stage.
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mvu_input_replay_buffer.sv
// rtl/mvu_input_replay_buffer.sv - captures SF-beat activation vectors and replays each NF times
// Ports:
//   ap_clk, ap_rst            : clock, asynchronous active-high reset
//   s_axis_input_*            : input stream (tdata/tvalid/tready)
//   m_axis_replay_*           : replay stream (tdata/tvalid/tready), tlast on the last beat of
//                               every pass, tfinal on the last beat of the last pass
// Optional (macro MVU_REPLAY_STATS_EN):
//   stat_used                 : registered slot occupancy
//   stat_stall_cycles         : saturating count of cycles with replay tvalid && !tready
module mvu_input_replay_buffer
  import mvu_replay_pkg::*;
#(
  parameter int SIMD             = 48,
  parameter int ACTIVATION_WIDTH = 4,
  parameter int SF               = 2,
  parameter int NF               = 2,
  parameter int DEPTH            = 2
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [SIMD*ACTIVATION_WIDTH-1:0] s_axis_input_tdata,
  input  logic                             s_axis_input_tvalid,
  output logic                             s_axis_input_tready,
  output logic [SIMD*ACTIVATION_WIDTH-1:0] m_axis_replay_tdata,
  output logic                             m_axis_replay_tvalid,
  input  logic                             m_axis_replay_tready,
  output logic                             m_axis_replay_tlast,
  output logic                             m_axis_replay_tfinal
`ifdef MVU_REPLAY_STATS_EN
  ,
  output logic [clog2_min1(DEPTH+1)-1:0]   stat_used,
  output logic [31:0]                      stat_stall_cycles
`endif
);

  localparam int DW      = beat_width(SIMD, ACTIVATION_WIDTH);
  localparam int BW      = clog2_min1(SF);
  localparam int PW      = clog2_min1(NF);
  localparam int SW      = clog2_min1(DEPTH);
  localparam int UW      = clog2_min1(DEPTH + 1);
  localparam int ENTRIES = DEPTH * SF;
  localparam int AW      = clog2_min1(ENTRIES);

  localparam logic [BW-1:0] BEAT_LAST = BW'(SF - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NF - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DEPTH - 1);
  localparam logic [UW-1:0] USED_FULL = UW'(DEPTH);

  logic [UW-1:0] used, used_next;
  logic [SW-1:0] wr_slot, rd_slot;
  logic [BW-1:0] wr_beat, rd_beat;
  logic [PW-1:0] rd_pass;
  replay_state_e state, state_next;

  logic in_fire, commit;
  logic issue, release_slot, stage_free, out_ready;
  logic s1_valid, s1_last, s1_final;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_addr, rd_addr;

  // ---------------- write side ----------------
  // Ready comes from registered occupancy only, so a release in the same
  // cycle as a full buffer does not reopen the input until the next cycle.
  assign s_axis_input_tready = !ap_rst && (used < USED_FULL);
  assign in_fire             = s_axis_input_tvalid && s_axis_input_tready;
  assign commit              = in_fire && (wr_beat == BEAT_LAST);
  assign wr_addr             = AW'(wr_slot) * AW'(SF) + AW'(wr_beat);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_slot <= '0;
      wr_beat <= '0;
    end else if (in_fire) begin
      if (wr_beat == BEAT_LAST) begin
        wr_beat <= '0;
        wr_slot <= (wr_slot == SLOT_LAST) ? '0 : wr_slot + 1'b1;
      end else begin
        wr_beat <= wr_beat + 1'b1;
      end
    end
  end

  // ---------------- read side ----------------
  assign out_ready  = !m_axis_replay_tvalid || m_axis_replay_tready;
  // The read register can take a new beat when empty or when it moves on into the output register.
  assign stage_free = !s1_valid || out_ready;
  assign rd_addr    = AW'(rd_slot) * AW'(SF) + AW'(rd_beat);

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    release_slot = 1'b0;
    used_next    = used;
    case (state)
      // Issuing straight from IDLE keeps the commit-to-first-beat latency at two cycles.
      IDLE: begin
        if (used != '0) begin
          issue      = stage_free;
          state_next = REPLAY;
        end
      end
      REPLAY:  issue = stage_free;
      default: state_next = IDLE;
    endcase
    release_slot = issue && (rd_beat == BEAT_LAST) && (rd_pass == PASS_LAST);
    case ({commit, release_slot})
      2'b10:   used_next = used + 1'b1;
      2'b01:   used_next = used - 1'b1;
      default: used_next = used;
    endcase
    if (release_slot && (used_next == '0)) state_next = IDLE;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state   <= IDLE;
      used    <= '0;
      rd_slot <= '0;
      rd_beat <= '0;
      rd_pass <= '0;
    end else begin
      state <= state_next;
      used  <= used_next;
      if (issue) begin
        if (rd_beat == BEAT_LAST) begin
          rd_beat <= '0;
          if (rd_pass == PASS_LAST) begin
            rd_pass <= '0;
            rd_slot <= (rd_slot == SLOT_LAST) ? '0 : rd_slot + 1'b1;
          end else begin
            rd_pass <= rd_pass + 1'b1;
          end
        end else begin
          rd_beat <= rd_beat + 1'b1;
        end
      end
    end
  end

  mvu_replay_mem #(
    .WIDTH  (DW),
    .ENTRIES(ENTRIES),
    .ADDR_W (AW)
  ) u_mem (
    .clk    (ap_clk),
    .wr_en  (in_fire),
    .wr_addr(wr_addr),
    .wr_data(s_axis_input_tdata),
    .rd_en  (issue),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Side-band flags travel alongside the registered read data.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_final <= 1'b0;
    end else if (issue) begin
      s1_valid <= 1'b1;
      s1_last  <= (rd_beat == BEAT_LAST);
      s1_final <= (rd_beat == BEAT_LAST) && (rd_pass == PASS_LAST);
    end else if (out_ready) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      m_axis_replay_tvalid <= 1'b0;
      m_axis_replay_tlast  <= 1'b0;
      m_axis_replay_tfinal <= 1'b0;
    end else if (out_ready) begin
      m_axis_replay_tvalid <= s1_valid;
      m_axis_replay_tlast  <= s1_valid && s1_last;
      m_axis_replay_tfinal <= s1_valid && s1_final;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (out_ready && s1_valid) m_axis_replay_tdata <= rd_data;
  end

`ifdef MVU_REPLAY_STATS_EN
  assign stat_used = used;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat_stall_cycles <= '0;
    end else if (m_axis_replay_tvalid && !m_axis_replay_tready && (stat_stall_cycles != '1)) begin
      stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mvu_input_replay_buffer.sv
// tb/tb_mvu_input_replay_buffer.sv - directed and table-driven checks of mvu_input_replay_buffer
module tb_mvu_input_replay_buffer;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ap_rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 1: SIMD=4, AW=4, SF=3, NF=2, DEPTH=2
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid, m_tlast, m_tfinal, m_tready;
  logic         rand_mode = 1'b0, force_rdy = 1'b1, rnd_bit = 1'b1;
  assign m_tready = rand_mode ? rnd_bit : force_rdy;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 99) < 70);

  // DUT 2: SF=1, NF=1, DEPTH=2
  logic [W-1:0] s2_tdata = '0;
  logic         s2_tvalid = 1'b0;
  logic         s2_tready;
  logic [W-1:0] m2_tdata;
  logic         m2_tvalid, m2_tlast, m2_tfinal;
  logic         m2_tready = 1'b0;

`ifdef MVU_REPLAY_STATS_EN
  logic [1:0]  stat_used, stat2_used;
  logic [31:0] stat_stall, stat2_stall;
`endif

  mvu_input_replay_buffer #(.SIMD(4), .ACTIVATION_WIDTH(4), .SF(3), .NF(2), .DEPTH(2)) dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .s_axis_input_tdata(s_tdata), .s_axis_input_tvalid(s_tvalid), .s_axis_input_tready(s_tready),
    .m_axis_replay_tdata(m_tdata), .m_axis_replay_tvalid(m_tvalid), .m_axis_replay_tready(m_tready),
    .m_axis_replay_tlast(m_tlast), .m_axis_replay_tfinal(m_tfinal)
`ifdef MVU_REPLAY_STATS_EN
    , .stat_used(stat_used), .stat_stall_cycles(stat_stall)
`endif
  );

  mvu_input_replay_buffer #(.SIMD(4), .ACTIVATION_WIDTH(4), .SF(1), .NF(1), .DEPTH(2)) dut2 (
    .ap_clk(clk), .ap_rst(ap_rst),
    .s_axis_input_tdata(s2_tdata), .s_axis_input_tvalid(s2_tvalid), .s_axis_input_tready(s2_tready),
    .m_axis_replay_tdata(m2_tdata), .m_axis_replay_tvalid(m2_tvalid), .m_axis_replay_tready(m2_tready),
    .m_axis_replay_tlast(m2_tlast), .m_axis_replay_tfinal(m2_tfinal)
`ifdef MVU_REPLAY_STATS_EN
    , .stat_used(stat2_used), .stat_stall_cycles(stat2_stall)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Output monitors sample mid-cycle; a beat counts as accepted when tvalid && tready there.
  logic [W-1:0] got_d[$];
  logic         got_l[$], got_f[$];
  int           got_c[$];
  logic [W-1:0] got2_d[$];
  logic         got2_l[$], got2_f[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (ap_rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {15'd0, m_tvalid, m_tdata}, {15'd0, 1'b1, prev_d});
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata); got_l.push_back(m_tlast);
        got_f.push_back(m_tfinal); got_c.push_back(cyc);
      end
      prev_stall <= m_tvalid && !m_tready;
      prev_d     <= m_tdata;
    end
  end

  always @(negedge clk) begin
    if (!ap_rst && m2_tvalid && m2_tready) begin
      got2_d.push_back(m2_tdata); got2_l.push_back(m2_tlast); got2_f.push_back(m2_tfinal);
    end
  end

  typedef struct packed {
    logic [2:0][W-1:0] in_b;    // in_b[0] is sent first
    logic [5:0][W-1:0] exp_d;   // exp_d[0] is the first replayed beat
    logic [5:0]        exp_last;
    logic [5:0]        exp_final;
  } vec_rec_t;

  vec_rec_t recs [4];
  int in_stalls = 0;
  int last_fire_cyc = 0;

  task automatic send_beat(input logic [W-1:0] d);
    int n;
    n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 1000) begin
      in_stalls++; n++;
      @(negedge clk);
    end
    if (!s_tready) check("send_timeout", {31'd0, s_tready}, 32'd1);
    last_fire_cyc = cyc;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_vec(input vec_rec_t r);
    for (int b = 0; b < 3; b++) send_beat(r.in_b[b]);
  endtask

  task automatic wait_out(input int n, input int budget);
    int k;
    k = 0;
    while (got_d.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    check("out_count", got_d.size(), n);
    @(posedge clk); #1;
  endtask

  task automatic clear_queues();
    got_d.delete(); got_l.delete(); got_f.delete(); got_c.delete();
    got2_d.delete(); got2_l.delete(); got2_f.delete();
    in_stalls = 0;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0; s2_tvalid = 1'b0;
    ap_rst = 1'b1;
    @(negedge clk);
    check("rst_s_tready", {31'd0, s_tready}, 0);
    check("rst_m_tvalid", {31'd0, m_tvalid}, 0);
    check("rst_m_tlast",  {31'd0, m_tlast}, 0);
    check("rst_m_tfinal", {31'd0, m_tfinal}, 0);
    @(posedge clk); @(posedge clk); #1;
    ap_rst = 1'b0;
    clear_queues();
    @(negedge clk);
    check("post_rst_s_tready", {31'd0, s_tready}, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ed[$];
    logic         el[$], ef[$];
    logic [W-1:0] v [3];
    int           commit_cyc, accepted, k;

    recs[0].in_b  = {16'h3333, 16'h2222, 16'h1111};
    recs[0].exp_d = {16'h3333, 16'h2222, 16'h1111, 16'h3333, 16'h2222, 16'h1111};
    recs[1].in_b  = {16'h6666, 16'h5555, 16'h4444};
    recs[1].exp_d = {16'h6666, 16'h5555, 16'h4444, 16'h6666, 16'h5555, 16'h4444};
    recs[2].in_b  = {16'h9999, 16'h8888, 16'h7777};
    recs[2].exp_d = {16'h9999, 16'h8888, 16'h7777, 16'h9999, 16'h8888, 16'h7777};
    recs[3].in_b  = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    recs[3].exp_d = {16'hCCCC, 16'hBBBB, 16'hAAAA, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    for (int r = 0; r < 4; r++) begin
      recs[r].exp_last  = 6'b100100;
      recs[r].exp_final = 6'b100000;
    end

    // T1: single vector; handshake at edge E, valid after E+2, so the mid-cycle stamps differ by 3
    do_reset();
    send_vec(recs[0]);
    commit_cyc = last_fire_cyc;
    wait_out(6, 50);
    if (got_d.size() >= 6) begin
      check("t1_latency", got_c[0] - commit_cyc, 3);
      for (int j = 0; j < 6; j++) begin
        check($sformatf("t1_data%0d", j), {16'd0, got_d[j]}, {16'd0, recs[0].exp_d[j]});
        check($sformatf("t1_last%0d", j), {31'd0, got_l[j]}, {31'd0, recs[0].exp_last[j]});
        check($sformatf("t1_final%0d", j), {31'd0, got_f[j]}, {31'd0, recs[0].exp_final[j]});
      end
    end
    repeat (10) @(posedge clk);
    #1;
    check("t1_no_extra", got_d.size(), 6);
    check("t1_drained_valid", {31'd0, m_tvalid}, 0);

    // T2: three vectors back-to-back; input blocked 3 cycles until vector 0 retires
    do_reset();
    for (int r = 0; r < 3; r++) send_vec(recs[r]);
    wait_out(18, 200);
    check("t2_in_stalls", in_stalls, 3);
    if (got_d.size() >= 18) begin
      for (int i = 0; i < 18; i++) begin
        check($sformatf("t2_data%0d", i), {16'd0, got_d[i]}, {16'd0, recs[i/6].exp_d[i%6]});
        check($sformatf("t2_last%0d", i), {31'd0, got_l[i]}, {31'd0, recs[i/6].exp_last[i%6]});
        check($sformatf("t2_final%0d", i), {31'd0, got_f[i]}, {31'd0, recs[i/6].exp_final[i%6]});
        if (i > 0) check($sformatf("t2_nobubble%0d", i), got_c[i] - got_c[i-1], 1);
      end
    end

    // T3: 20 random vectors with ~70% output ready
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int b = 0; b < 3; b++) v[b] = W'($urandom);
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 3; b++) begin
          ed.push_back(v[b]); el.push_back(b == 2); ef.push_back(b == 2 && p == 1);
        end
      for (int b = 0; b < 3; b++) send_beat(v[b]);
    end
    wait_out(120, 3000);
    if (got_d.size() >= 120) begin
      for (int i = 0; i < 120; i++) begin
        check($sformatf("t3_data%0d", i), {16'd0, got_d[i]}, {16'd0, ed[i]});
        check($sformatf("t3_flags%0d", i), {30'd0, got_l[i], got_f[i]}, {30'd0, el[i], ef[i]});
      end
    end
    rand_mode = 1'b0;

    // T4: SF=1, NF=1 instance; 2 slots plus read and output registers hold 4 beats when stalled
    do_reset();
    m2_tready = 1'b0;
    accepted  = 0;
    s2_tdata  = 16'hA001;
    s2_tvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      k = {31'd0, s2_tready};
      @(posedge clk); #1;
      if (k != 0) begin accepted++; s2_tdata = 16'hA001 + W'(accepted); end
    end
    @(negedge clk);
    check("t4_accepted_stalled", accepted, 4);
    check("t4_full_tready", {31'd0, s2_tready}, 0);
    check("t4_head_valid", {31'd0, m2_tvalid}, 1);
    check("t4_head_data", {16'd0, m2_tdata}, 32'hA001);
    @(posedge clk); #1;
    m2_tready = 1'b1;
    k = 0;
    while (accepted < 8 && k < 100) begin
      @(negedge clk);
      if (s2_tready) begin
        @(posedge clk); #1;
        accepted++; s2_tdata = 16'hA001 + W'(accepted);
      end else begin
        @(posedge clk); #1;
      end
      k++;
    end
    s2_tvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t4_out_count", got2_d.size(), 8);
    if (got2_d.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t4_data%0d", i), {16'd0, got2_d[i]}, 32'hA001 + i);
        check($sformatf("t4_lastfinal%0d", i), {30'd0, got2_l[i], got2_f[i]}, 32'd3);
      end
    end

    // T5: reset while vector 0 replays and vector 1 is half written
    do_reset();
    send_vec(recs[0]);
    send_beat(16'h5555);
    send_beat(16'h6666);
    @(negedge clk);
    check("t5_pre_valid", {31'd0, m_tvalid}, 1);
    #1 ap_rst = 1'b1;
    #1;
    check("t5_async_tvalid", {31'd0, m_tvalid}, 0);
    check("t5_async_tlast", {31'd0, m_tlast}, 0);
    check("t5_async_tfinal", {31'd0, m_tfinal}, 0);
    check("t5_async_s_tready", {31'd0, s_tready}, 0);
    @(posedge clk); @(posedge clk); #1;
    ap_rst = 1'b0;
    clear_queues();
    @(negedge clk);
    check("t5_post_s_tready", {31'd0, s_tready}, 1);
    @(posedge clk); #1;
    send_vec(recs[3]);
    wait_out(6, 50);
    if (got_d.size() >= 6) begin
      for (int j = 0; j < 6; j++)
        check($sformatf("t5_data%0d", j), {16'd0, got_d[j]}, {16'd0, recs[3].exp_d[j]});
    end
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_stale", got_d.size(), 6);

`ifdef MVU_REPLAY_STATS_EN
    // T6: two vectors buffered, output held off for 10 cycles
    do_reset();
    force_rdy = 1'b0;
    send_vec(recs[0]);
    send_vec(recs[1]);
    @(negedge clk);
    check("t6_valid", {31'd0, m_tvalid}, 1);
    k = int'(stat_stall);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t6_stall_cycles", stat_stall - 32'(k), 10);
    check("t6_stat_used", {30'd0, stat_used}, 2);
    @(posedge clk); #1;
    force_rdy = 1'b1;
    wait_out(12, 100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
